// File: rtl/hex_pkg.sv
// Shared codes for the seven-segment status display and the match sequencer FSM.
package hex_pkg;

  localparam logic [2:0] S_HEX_1P    = 3'd0;
  localparam logic [2:0] S_HEX_2P    = 3'd1;
  localparam logic [2:0] S_HEX_FIGHT = 3'd2;
  localparam logic [2:0] S_HEX_P1WIN = 3'd3;
  localparam logic [2:0] S_HEX_P2WIN = 3'd4;
  localparam logic [2:0] S_HEX_EQ    = 3'd5;
  localparam logic [2:0] S_HEX_DEBUG = 3'd6;

  localparam int DUR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTRO,
    ST_PLAY,
    ST_P1W,
    ST_P2W,
    ST_DRAW
  } fsm_state_t;

  // PLAY shows the debug/timer page so the display renders the running seconds.
  function automatic logic [2:0] state_code(fsm_state_t s, logic mode_2p);
    logic [2:0] code;
    case (s)
      ST_IDLE:  code = mode_2p ? S_HEX_2P : S_HEX_1P;
      ST_INTRO: code = S_HEX_FIGHT;
      ST_PLAY:  code = S_HEX_DEBUG;
      ST_P1W:   code = S_HEX_P1WIN;
      ST_P2W:   code = S_HEX_P2WIN;
      ST_DRAW:  code = S_HEX_EQ;
      default:  code = S_HEX_1P;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/game_status_sequencer_prescaler.sv
// One-second tick generator; counter is held at zero whenever it is not enabled.
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/game_status_sequencer.sv
// Match lifecycle sequencer: drives the display state code and elapsed match seconds.
module game_status_sequencer
  import hex_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int INTRO_S = 2,
  parameter int MAX_S   = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_2p,
  input  logic             start,
  input  logic             p1_win,
  input  logic             p2_win,
  input  logic             debug_en,
  output logic [2:0]       hex_state,
  output logic [DUR_W-1:0] game_duration,
  output logic             game_active
);

  localparam int IC_W = $clog2(INTRO_S + 1);
  localparam logic [IC_W-1:0]  INTRO_END = IC_W'(INTRO_S);
  localparam logic [DUR_W-1:0] DUR_MAX   = DUR_W'(MAX_S);

  fsm_state_t       state, state_next;
  logic             start_p0, start_p1;
  logic             start_rise;
  logic             sec_tick;
  logic             pre_clr, pre_en;
  logic [IC_W-1:0]  intro_cnt, intro_cnt_next;
  logic [DUR_W-1:0] dur_next;
  logic [2:0]       hex_next;
  logic             active_next;

  assign start_rise = start_p0 && !start_p1;
  assign pre_en     = (state == ST_INTRO) || (state == ST_PLAY);

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (sec_tick)
  );

  // The selected mode is only ever shown in IDLE, so the live level is displayed there.
  always_comb begin
    state_next     = state;
    intro_cnt_next = intro_cnt;
    dur_next       = game_duration;
    pre_clr        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_next     = ST_INTRO;
          intro_cnt_next = '0;
          dur_next       = '0;
          pre_clr        = 1'b1;
        end
      end
      ST_INTRO: begin
        if (sec_tick) begin
          intro_cnt_next = intro_cnt + IC_W'(1);
          if (intro_cnt_next == INTRO_END) begin
            state_next = ST_PLAY;
            pre_clr    = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (sec_tick && (game_duration < DUR_MAX))
          dur_next = game_duration + DUR_W'(1);
        if (p1_win && p2_win)
          state_next = ST_DRAW;
        else if (p1_win)
          state_next = ST_P1W;
        else if (p2_win)
          state_next = ST_P2W;
        else if (sec_tick && (dur_next == DUR_MAX))
          state_next = ST_DRAW;
      end
      ST_P1W, ST_P2W, ST_DRAW: begin
        if (start_rise)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    hex_next    = debug_en ? S_HEX_DEBUG : state_code(state_next, mode_2p);
    active_next = (state_next == ST_PLAY);
  end

  // Outputs are registered from the next-state values so they change with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      start_p0      <= 1'b1;
      start_p1      <= 1'b1;
      intro_cnt     <= '0;
      game_duration <= '0;
      hex_state     <= S_HEX_1P;
      game_active   <= 1'b0;
    end else begin
      state         <= state_next;
      start_p0      <= start;
      start_p1      <= start_p0;
      intro_cnt     <= intro_cnt_next;
      game_duration <= dur_next;
      hex_state     <= hex_next;
      game_active   <= active_next;
    end
  end

endmodule
